// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register addresses,
// status bit positions and the transmitter state encoding.
package riscv_mmio_pkg;

  localparam logic [7:0] MMIO_TXDATA_ADDR = 8'hF0;
  localparam logic [7:0] MMIO_STATUS_ADDR = 8'hF4;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  function automatic logic [31:0] status_word(input logic ovf, input logic empty,
                                              input logic full, input logic busy);
    logic [31:0] w;
    w             = '0;
    w[STAT_OVF]   = ovf;
    w[STAT_EMPTY] = empty;
    w[STAT_FULL]  = full;
    w[STAT_BUSY]  = busy;
    return w;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by MMIO peripherals: store path in, status read path out.
interface mmio_uart_tx_if;
  logic        dm_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] rd_data;
  logic        hit;

  modport master (
    output dm_we, mem_addr, mem_wd,
    input  rd_data, hit
  );

  modport slave (
    input  dm_we, mem_addr, mem_wd,
    output rd_data, hit
  );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset; head word is read combinationally.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TX data/status register decode, byte FIFO, 8N1 serialiser.
//   state    | meaning
//   ST_IDLE  | line high; pops the FIFO head when one is waiting
//   ST_START | start bit (low) for one bit period
//   ST_DATA  | eight data bits, LSB first, one bit period each
//   ST_STOP  | stop bit (high) for one bit period
module mmio_uart_tx
  import riscv_mmio_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] TXDATA_ADDR  = MMIO_TXDATA_ADDR,
  parameter logic [7:0] STATUS_ADDR  = MMIO_STATUS_ADDR
) (
  input  logic            clk,
  input  logic            rset,
  mmio_uart_tx_if.slave   bus,
  output logic            tx,
  output logic            busy
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam int             AW        = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_nxt;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          baud_last;
  logic          pop;

  logic          tx_sel, st_sel;
  logic          push_req, push, ovf_set, ovf_clr, ovf;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;
  logic          unused_ok;

  assign tx_sel   = (bus.mem_addr == TXDATA_ADDR);
  assign st_sel   = (bus.mem_addr == STATUS_ADDR);
  assign push_req = bus.dm_we && tx_sel;
  // Fullness is judged before any same-cycle pop, so a write to a full FIFO is lost.
  assign push     = push_req && !fifo_full;
  assign ovf_set  = push_req && fifo_full;
  assign ovf_clr  = bus.dm_we && st_sel && bus.mem_wd[3];

  assign bus.hit     = tx_sel || st_sel;
  assign bus.rd_data = st_sel ? status_word(ovf, fifo_empty, fifo_full, busy) : '0;
  assign busy        = (state != ST_IDLE) || !fifo_empty;
  assign baud_last   = (baud_cnt == BAUD_LAST);
  assign unused_ok   = ^{bus.mem_wd[31:8], bus.mem_wd[2:0], fifo_count};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rset  (rset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.mem_wd[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rset) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty)                 state_nxt = ST_START;
      ST_START: if (baud_last)                   state_nxt = ST_DATA;
      ST_DATA:  if (baud_last && bit_idx == 3'd7) state_nxt = ST_STOP;
      ST_STOP:  if (baud_last)                   state_nxt = ST_IDLE;
      default:                                   state_nxt = ST_IDLE;
    endcase
  end

  // tx is computed from the next state so the line moves on the same edge as the FSM.
  always_comb begin
    pop       = 1'b0;
    baud_nxt  = baud_last ? '0 : baud_cnt + BW'(1);
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    case (state)
      ST_IDLE: begin
        baud_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_rdata;
        end
      end
      ST_START: if (baud_last) bit_nxt = '0;
      ST_DATA: begin
        if (baud_last) begin
          shift_nxt = {1'b0, shift[7:1]};
          bit_nxt   = bit_idx + 3'd1;
        end
      end
      default: ;
    endcase
    case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = shift_nxt[0];
      default:  tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: decode table, hand-built frame sequences and random traffic
// against a frame-timeline model, with an independent line receiver.
module tb_mmio_uart_tx;

  localparam int C = 4;
  localparam int D = 4;
  localparam logic [7:0] A_TX = 8'hF0;
  localparam logic [7:0] A_ST = 8'hF4;

  logic clk;
  logic rset;
  logic tx;
  logic busy;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk  (clk),
    .rset (rset),
    .bus  (bus.slave),
    .tx   (tx),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: queue of waiting bytes plus the position inside the frame being sent.
  logic [7:0] mq[$];
  logic [7:0] done_q[$];
  logic [7:0] cur;
  int         pos  = -1;
  logic       movf = 1'b0;

  function automatic logic m_tx();
    int fb;
    if (pos < 0) return 1'b1;
    fb = pos / C;
    if (fb == 0) return 1'b0;
    if (fb == 9) return 1'b1;
    return cur[fb-1];
  endfunction

  function automatic logic m_busy();
    return (pos >= 0) || (mq.size() > 0);
  endfunction

  function automatic logic [31:0] m_rd(input logic [7:0] a);
    if (a != A_ST) return 32'h0;
    return {28'h0, movf, mq.size() == 0, mq.size() == D, m_busy()};
  endfunction

  task automatic model_update(input logic r, input logic we, input logic [7:0] a,
                              input logic [31:0] d);
    int sz;
    if (!r) begin
      mq.delete();
      pos  = -1;
      movf = 1'b0;
    end else begin
      sz = mq.size();
      if (pos >= 0) begin
        pos++;
        if (pos == 10*C) begin
          done_q.push_back(cur);
          pos = -1;
        end
      end else if (sz > 0) begin
        cur = mq.pop_front();
        pos = 0;
      end
      if (we && a == A_TX) begin
        if (sz < D) mq.push_back(d[7:0]);
        else        movf = 1'b1;
      end else if (we && a == A_ST && d[3]) begin
        movf = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [7:0] a, input logic [31:0] d);
    rset         = r;
    bus.dm_we    = we;
    bus.mem_addr = a;
    bus.mem_wd   = d;
    #1;
    chk("tx",      32'(tx),          32'(m_tx()));
    chk("busy",    32'(busy),        32'(m_busy()));
    chk("hit",     32'(bus.hit),     32'((a == A_TX) || (a == A_ST)));
    chk("rd_data", bus.rd_data,      m_rd(a));
    @(posedge clk);
    model_update(r, we, a, d);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [7:0] a);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, a, 32'h0);
  endtask

  // Receiver: finds the start bit and samples each bit in the middle of its window.
  logic [7:0] rx_q[$];
  initial begin
    int         rx_n;
    int         b;
    logic [7:0] rx_b;
    rx_n = -1;
    rx_b = '0;
    forever begin
      @(negedge clk);
      if (rset !== 1'b1) begin
        rx_n = -1;
      end else if (rx_n < 0) begin
        if (tx === 1'b0) rx_n = 0;
      end else begin
        rx_n++;
        if (rx_n % C == C/2) begin
          b = rx_n / C;
          if (b >= 1 && b <= 8) begin
            rx_b[b-1] = tx;
          end else if (b == 9) begin
            chk("rx_stop_bit", 32'(tx), 32'h1);
            rx_q.push_back(rx_b);
            rx_n = -1;
          end
        end
      end
    end
  end

  task automatic chk_rx(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, 32'(rx_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      chk({name, "_byte"}, 32'(rx_q[i]), 32'(exp[i]));
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] exp_b[$];
  int         a5_bits[10];

  initial begin
    vecs[0] = '{1'b1, 8'h10, 32'h0000_00A5, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 8'hF0, 32'h0,         1'b1, 32'h0};
    vecs[2] = '{1'b0, 8'hF4, 32'h0,         1'b1, 32'h4};
    vecs[3] = '{1'b0, 8'hF1, 32'h0,         1'b0, 32'h0};
    vecs[4] = '{1'b0, 8'hF5, 32'h0,         1'b0, 32'h0};
    vecs[5] = '{1'b0, 8'h00, 32'h0,         1'b0, 32'h0};
    vecs[6] = '{1'b0, 8'hFF, 32'h0,         1'b0, 32'h0};
    vecs[7] = '{1'b0, 8'h74, 32'h0,         1'b0, 32'h0};
    vecs[8] = '{1'b1, 8'hF4, 32'h0000_0008, 1'b1, 32'h4};
    a5_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    // Reset held for two edges while a TX write is presented.
    rset         = 1'b0;
    bus.dm_we    = 1'b1;
    bus.mem_addr = A_TX;
    bus.mem_wd   = 32'h0000_0012;
    @(posedge clk);
    @(negedge clk);
    model_update(1'b0, 1'b1, A_TX, 32'h12);
    step(1'b0, 1'b1, A_TX, 32'h0000_0012);
    step(1'b1, 1'b0, A_ST, 32'h0);
    chk("reset_tx",     32'(tx),     32'h1);
    chk("reset_busy",   32'(busy),   32'h0);
    chk("reset_status", bus.rd_data, 32'h4);
    idle(6, A_ST);
    chk("reset_nothing_queued", bus.rd_data, 32'h4);

    // Address decode table.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wd);
      chk("table_hit", 32'(bus.hit), 32'(vecs[i].exp_hit));
      chk("table_rd",  bus.rd_data,  vecs[i].exp_rd);
    end
    idle(3, 8'h00);
    chk("stray_write_no_busy", 32'(busy), 32'h0);
    chk("stray_write_tx",      32'(tx),   32'h1);

    // Single byte A5 with explicit waveform.
    rx_q.delete();
    step(1'b1, 1'b1, A_TX, 32'hFFFF_FFA5);
    for (int n = 0; n <= 44; n++) begin
      if (n == 0 || n > 40) chk("a5_tx_idle", 32'(tx), 32'h1);
      else                  chk("a5_tx_bit",  32'(tx), 32'(a5_bits[(n-1)/C]));
      chk("a5_busy", 32'(busy), 32'(n < 41));
      step(1'b1, 1'b0, 8'h00, 32'h0);
    end
    exp_b = '{8'hA5};
    chk_rx("a5_rx", exp_b);

    // Back-to-back frames.
    rx_q.delete();
    step(1'b1, 1'b1, A_TX, 32'h0000_0055);
    step(1'b1, 1'b1, A_TX, 32'h0000_000F);
    for (int n = 1; n <= 90; n++) begin
      if (n == 41) chk("b2b_gap_high",   32'(tx), 32'h1);
      if (n == 42) chk("b2b_second_start", 32'(tx), 32'h0);
      if (n == 20) chk("b2b_status_mid", bus.rd_data, 32'h1);
      if (n == 85) chk("b2b_status_end", bus.rd_data, 32'h4);
      step(1'b1, 1'b0, A_ST, 32'h0);
    end
    exp_b = '{8'h55, 8'h0F};
    chk_rx("b2b_rx", exp_b);

    // Overflow: six consecutive writes into a four-deep FIFO.
    rx_q.delete();
    step(1'b1, 1'b1, A_TX, 32'h11);
    step(1'b1, 1'b1, A_TX, 32'h22);
    step(1'b1, 1'b1, A_TX, 32'h33);
    step(1'b1, 1'b1, A_TX, 32'h44);
    step(1'b1, 1'b1, A_TX, 32'h66);
    step(1'b1, 1'b1, A_TX, 32'h77);
    step(1'b1, 1'b0, A_ST, 32'h0);
    chk("ovf_status", bus.rd_data, 32'hB);
    step(1'b1, 1'b1, A_ST, 32'h8);
    chk("ovf_cleared", bus.rd_data, 32'h3);
    idle(5*42 + 10, A_ST);
    chk("ovf_drained", bus.rd_data, 32'h4);
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
    chk_rx("ovf_rx", exp_b);

    // Reset in the middle of data bit 3, with a second byte still queued.
    rx_q.delete();
    step(1'b1, 1'b1, A_TX, 32'hAB);
    step(1'b1, 1'b1, A_TX, 32'hCD);
    idle(17, A_ST);
    step(1'b0, 1'b0, A_ST, 32'h0);
    chk("midrst_tx",     32'(tx),     32'h1);
    chk("midrst_status", bus.rd_data, 32'h4);
    idle(100, A_ST);
    chk("midrst_no_frames", 32'(rx_q.size()), 32'h0);

    // Random traffic against the model.
    rx_q.delete();
    done_q.delete();
    for (int i = 0; i < 2500; i++) begin
      int          r;
      logic [7:0]  a;
      logic [31:0] d;
      r = $urandom_range(0, 9);
      d = $urandom;
      if (r < 4)      a = A_TX;
      else if (r < 6) a = A_ST;
      else            a = 8'($urandom);
      step(1'b1, $urandom_range(0, 3) == 0, a, d);
    end
    idle(6*42, A_ST);
    chk_rx("rand_rx", done_q);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the core's data-memory bus, in parallel with the data memory. It consumes the core's store traffic (write enable, 8-bit address, 32-bit write data) and returns a status word on the read path. Bytes written to the TX register are buffered in a small FIFO and serialised 8N1, LSB first, on a single output line. The surrounding top/bench muxes its read data over the data memory's when the hit output is high.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2)
FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2)
TXDATA_ADDR, 8'hF0, byte address of TX data register (write-only)
STATUS_ADDR, 8'hF4, byte address of status register (read; write clears overflow)

Ports:
clk  in  1  system clock, rising-edge
rset  in  1  synchronous reset, active-low
dm_we  in  1  data-memory write enable from core
mem_addr  in  8  data-memory byte address from core
mem_wd  in  32  store data from core
rd_data  out  32  status read data, combinational
hit  out  1  high when mem_addr equals TXDATA_ADDR or STATUS_ADDR, combinational
tx  out  1  serial line, registered, idle high
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- One clock; reset is synchronous and active-low. While rset=0 at a rising edge: tx=1, FSM=IDLE, FIFO emptied (pointers and count 0), baud counter 0, bit index 0, overflow=0. Reset mid-frame aborts the frame, and tx is 1 after that edge.
- Push: dm_we=1 and mem_addr==TXDATA_ADDR at an edge with count<FIFO_DEPTH stores mem_wd[7:0]. mem_wd[31:8] is ignored.
- Overflow: the same write with count==FIFO_DEPTH is dropped and sets overflow, even if a pop occurs in the same cycle. There is no full bypass.
- Overflow clear: dm_we=1 and mem_addr==STATUS_ADDR with mem_wd[3]=1 clears overflow. If a set and a clear occur in the same cycle, set wins.
- Status word: rd_data = {28'b0, overflow, empty, full, busy} when mem_addr==STATUS_ADDR. Otherwise rd_data=0, including on TXDATA_ADDR reads.
- FSM states:
  - IDLE: tx=1. If count>0, pop the head into the shift register, clear the baud counter, go to START. An empty FIFO is never popped, and there is no same-cycle push-to-pop bypass.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- tx is registered and driven from the next-state value, so the line change coincides with the state change.
- Latency: a push at edge k makes the FIFO non-empty. The pop happens at edge k+1, and tx falls at edge k+1.
- Frame length is 10*CLKS_PER_BIT cycles. Back-to-back frames have exactly 1 IDLE cycle (tx=1) between the STOP end and the next START.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is held in log2(FIFO_DEPTH)+1 bits.
- A simultaneous push and pop with count not full leaves count unchanged.

Decomposition:
- Shared package riscv_mmio_pkg holds:
  - the TXDATA/STATUS address constants
  - status bit positions (BUSY=0, FULL=1, EMPTY=2, OVF=3)
  - the UART FSM state encoding (IDLE, START, DATA, STOP, 2-bit)
- One sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count, same reset), instantiated with width 8.
- The FSM, baud counter and address decode stay in mmio_uart_tx.

Test Plan:
- Reset: hold rset=0 for 2 edges with dm_we=1 to TXDATA -> tx=1, busy=0, STATUS read=32'h4, nothing queued after release.
- Single byte (CLKS_PER_BIT=4): write 32'hFFFF_FFA5 to 8'hF0 -> tx low from edge k+1 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. busy drops 41 cycles after the write.
- Back-to-back: write 8'h55 then 8'h0F on consecutive cycles -> two frames with exactly one idle-high cycle between them. STATUS reads 32'h1 mid-stream and 32'h4 at the end.
- Overflow: 6 consecutive writes (FIFO_DEPTH=4) -> first pops at once, next 4 fill the FIFO, 6th dropped. STATUS=32'hB (overflow, full, busy). Writing 32'h8 to 8'hF4 -> overflow=0. Exactly 5 frames are emitted.
- Address decode: write to 8'h10 -> hit=0, no push. Read 8'hF0 -> hit=1, rd_data=0.
- Reset mid-frame: assert rset=0 during DATA bit 3 -> tx=1 at the next edge, FIFO empty, and no further frames after release.
